icache_fill_fsm: RTL and testbench
==================================

Name: icache_fill_fsm

Overview:
- Miss-handling controller directly upstream of the instruction cache.
- On a cache miss it fetches the full 16-byte block (8 x 16-bit words) from pipelined multi-cycle main memory.
- It writes each returned word into the cache data array and writes the tag/valid entry with the final word.
- It holds fsm_busy to stall fetch for the whole fill.

Parameters:
ADDR_W, 16, address/data width in bits
WORDS, 8, 16-bit words per cache block (byte offset = address[3:0], word stride 2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
miss_detected  input  1  cache reports miss for miss_address this cycle
miss_address  input  16  byte address that missed
memory_data_valid  input  1  memory_data carries a returned word this cycle
memory_data  input  16  word returned by memory, in request order
mem_read  output  1  read request to memory this cycle
memory_address  output  16  address of current memory request
fsm_busy  output  1  fill in progress; fetch/pipeline must stall
write_data_array  output  1  write cache_data into data array at cache_address
write_tag_array  output  1  write tag/valid for block of cache_address
cache_address  output  16  word address for the cache write
cache_data  output  16  word to write (= memory_data)

Behaviour:
- States: IDLE, FILL. Registers: base[15:0], issue_cnt[3:0] (0..8), recv_cnt[2:0].
- Reset (rst low, any time, async): state IDLE; base, issue_cnt, recv_cnt = 0.
- During reset all outputs are 0, including mem_read, fsm_busy, write_data_array, write_tag_array, memory_address, cache_address, cache_data.
- Reset mid-fill abandons the fill. No further writes are made. Already-written words remain in the data array. The tag is not written, so the block stays invalid.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the stall applies in the miss cycle).
  - On miss_detected: base <= {miss_address[15:4], 4'b0}; issue_cnt <= 0; recv_cnt <= 0; next state FILL.
  - mem_read = 0.
  - memory_data_valid in IDLE is ignored (no writes).
- FILL:
  - fsm_busy = 1.
  - mem_read = (issue_cnt < 8).
  - memory_address = base + 2*issue_cnt[2:0].
  - issue_cnt increments each cycle while < 8, then saturates at 8.
  - Memory is fully pipelined and accepts one request per cycle. The first request is issued in the first FILL cycle. Requests 0..7 are issued in 8 consecutive cycles.
  - Returns arrive in order with arbitrary latency ≥1 and may have gaps. Receive logic is independent of issue logic.
  - On memory_data_valid:
    - write_data_array = 1 (combinational).
    - cache_address = base + 2*recv_cnt.
    - cache_data = memory_data.
    - recv_cnt increments.
  - When memory_data_valid && recv_cnt == 7:
    - write_tag_array = 1 in the same cycle.
    - cache_address is the last word address, which carries the block's tag and index.
    - Next state is IDLE, and fsm_busy deasserts the following cycle.
  - miss_detected is ignored while in FILL.
- When not writing, write_data_array/write_tag_array = 0. cache_address and cache_data are then 0, as is memory_address when mem_read = 0.
- Back-to-back misses: miss_detected in the first IDLE cycle after a fill starts a new fill immediately.
- Address arithmetic is 16-bit. The block never wraps past base+14 because base is 16-byte aligned.
- Fill time with fixed latency L: 8 + L cycles from the first FILL cycle to the write_tag_array cycle (inclusive count 7+L+1).

Test Plan:
- Reset: hold rst=0 with random inputs -> all outputs 0. Release -> IDLE, fsm_busy=0 until miss.
- Single miss, miss_address=0x1236, memory latency 4:
  - fsm_busy=1 in the miss cycle.
  - memory_address = 0x1230, 0x1232, …, 0x123E on 8 consecutive cycles.
  - 8 writes at cache_address 0x1230..0x123E with matching data.
  - write_tag_array only on the 0x123E write.
  - fsm_busy low the next cycle.
- Gapped returns: memory_data_valid with random 0–3 cycle bubbles -> exactly 8 writes in order, tag on the 8th, no extra writes. miss_detected held high throughout FILL is ignored.
- Reset mid-fill: assert rst after 3 words written -> outputs 0 immediately, no tag write. A subsequent miss at 0x0000 fills 0x0000..0x000E correctly.
- Back-to-back: a miss at 0xFFF0 then a miss at 0x0010 the cycle after completion -> second fill starts without an idle gap. Addresses are 0xFFF0..0xFFFE then 0x0010..0x001E, with no wrap errors.
- Spurious memory_data_valid in IDLE -> no write_data_array, no state change.

Source files
------------

// File: rtl/icache_fill_fsm.sv
// Instruction-cache miss handler: fetches an aligned block from pipelined memory,
// streams each returned word into the data array and writes the tag with the last word.
module icache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [ADDR_W-1:0] memory_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] memory_address,
  output logic              fsm_busy,
  output logic              write_data_array,
  output logic              write_tag_array,
  output logic [ADDR_W-1:0] cache_address,
  output logic [ADDR_W-1:0] cache_data
);

  localparam int WI    = $clog2(WORDS);      // word index width
  localparam int OFF_W = WI + 1;             // byte offset width (16-bit words)

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t         state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [WI:0]    issue_cnt_reg, issue_cnt_next;
  logic [WI-1:0]  recv_cnt_reg, recv_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  // Outputs are gated by rst so they read 0 for the whole time reset is held.
  always_comb begin
    state_next       = state_reg;
    base_next        = base_reg;
    issue_cnt_next   = issue_cnt_reg;
    recv_cnt_next    = recv_cnt_reg;
    mem_read         = 1'b0;
    memory_address   = '0;
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    cache_address    = '0;
    cache_data       = '0;

    if (rst) begin
      case (state_reg)
        IDLE: begin
          fsm_busy = miss_detected;
          if (miss_detected) begin
            base_next      = {miss_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            issue_cnt_next = '0;
            recv_cnt_next  = '0;
            state_next     = FILL;
          end
        end
        FILL: begin
          fsm_busy = 1'b1;
          // Issue side: one request per cycle until all words are requested.
          if (issue_cnt_reg < (WI+1)'(WORDS)) begin
            mem_read       = 1'b1;
            memory_address = base_reg + ADDR_W'({issue_cnt_reg[WI-1:0], 1'b0});
            issue_cnt_next = issue_cnt_reg + 1'b1;
          end
          // Receive side runs independently; returns are in request order.
          if (memory_data_valid) begin
            write_data_array = 1'b1;
            cache_address    = base_reg + ADDR_W'({recv_cnt_reg, 1'b0});
            cache_data       = memory_data;
            recv_cnt_next    = recv_cnt_reg + 1'b1;
            if (recv_cnt_reg == WI'(WORDS - 1)) begin
              write_tag_array = 1'b1;
              state_next      = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_fsm.sv
// Directed bench for icache_fill_fsm: a small in-order memory responder drives returns,
// and every output is compared each cycle against the hand-derived fill schedule.
module tb_icache_fill_fsm;

  logic        clk;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        fsm_busy;
  logic        write_data_array;
  logic        write_tag_array;
  logic [15:0] cache_address;
  logic [15:0] cache_data;

  int checks_cnt;
  int errors_cnt;

  icache_fill_fsm #(.ADDR_W(16), .WORDS(8)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .mem_read          (mem_read),
    .memory_address    (memory_address),
    .fsm_busy          (fsm_busy),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .cache_address     (cache_address),
    .cache_data        (cache_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_value({tag, "_rd"},   16'(mem_read), 16'd0);
    check_value({tag, "_madr"}, memory_address, 16'd0);
    check_value({tag, "_busy"}, 16'(fsm_busy), 16'd0);
    check_value({tag, "_wr"},   16'(write_data_array), 16'd0);
    check_value({tag, "_tag"},  16'(write_tag_array), 16'd0);
    check_value({tag, "_cadr"}, cache_address, 16'd0);
    check_value({tag, "_cdat"}, cache_data, 16'd0);
  endtask

  task automatic idle_cycle(input bit spurious);
    miss_detected     = 1'b0;
    miss_address      = 16'($urandom);
    memory_data_valid = spurious;
    memory_data       = 16'($urandom);
    @(negedge clk);
    check_all_zero(spurious ? "idle_spur" : "idle");
    $display("idle cycle valid=%0d busy=%0d wr=%0d", spurious, fsm_busy, write_data_array);
    @(posedge clk); #1;
  endtask

  // Miss cycle followed by the fill. Word n is requested in fill cycle n and returns
  // no earlier than cycle n+lat, with up to gapmax random bubbles between returns.
  task automatic do_fill(input logic [15:0] maddr, input int lat, input int gapmax,
                         input bit hold_miss, input int abort_after);
    logic [15:0] b;
    logic [15:0] drv_data;
    int nrecv, c, next_ok;
    bit done, aborted;
    b = {maddr[15:4], 4'h0};
    miss_detected     = 1'b1;
    miss_address      = maddr;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    @(negedge clk);
    check_value("miss_busy", 16'(fsm_busy), 16'd1);
    check_value("miss_rd", 16'(mem_read), 16'd0);
    @(posedge clk); #1;
    miss_detected = hold_miss;
    miss_address  = 16'hBEE0;
    nrecv = 0; c = 0; next_ok = 0; done = 1'b0; aborted = 1'b0;
    while (!done && !aborted && c < 200) begin
      memory_data_valid = 1'b0;
      memory_data       = 16'h0;
      drv_data          = 16'h0;
      if (nrecv < 8 && c >= nrecv + lat && c >= next_ok) begin
        drv_data          = 16'($urandom);
        memory_data_valid = 1'b1;
        memory_data       = drv_data;
      end
      @(negedge clk);
      check_value("fill_busy", 16'(fsm_busy), 16'd1);
      if (c < 8) begin
        check_value("fill_rd", 16'(mem_read), 16'd1);
        check_value("fill_madr", memory_address, b + 16'(2 * c));
      end else begin
        check_value("fill_rd_done", 16'(mem_read), 16'd0);
        check_value("fill_madr_done", memory_address, 16'd0);
      end
      if (memory_data_valid) begin
        check_value("wr", 16'(write_data_array), 16'd1);
        check_value("wr_cadr", cache_address, b + 16'(2 * nrecv));
        check_value("wr_cdat", cache_data, drv_data);
        check_value("wr_tag", 16'(write_tag_array), 16'(nrecv == 7));
        $display("write word %0d addr=%h data=%h tag=%0d", nrecv, cache_address, cache_data,
                 write_tag_array);
        nrecv++;
        next_ok = c + 1 + int'($urandom_range(0, gapmax));
        if (nrecv == 8) done = 1'b1;
      end else begin
        check_value("nowr", 16'(write_data_array), 16'd0);
        check_value("nowr_tag", 16'(write_tag_array), 16'd0);
        check_value("nowr_cadr", cache_address, 16'd0);
        check_value("nowr_cdat", cache_data, 16'd0);
      end
      if (abort_after >= 0 && nrecv == abort_after) begin
        // Reset lands mid-cycle; outputs must collapse at once even with live inputs.
        #1;
        rst = 1'b0;
        memory_data_valid = 1'b1;
        miss_detected     = 1'b1;
        #1;
        check_all_zero("abort_now");
        for (int i = 0; i < 2; i++) begin
          @(posedge clk); #1;
          miss_detected     = 1'($urandom);
          memory_data_valid = 1'($urandom);
          memory_data       = 16'($urandom);
          @(negedge clk);
          check_all_zero("abort_hold");
        end
        @(posedge clk); #1;
        miss_detected     = 1'b0;
        memory_data_valid = 1'b0;
        rst               = 1'b1;
        aborted           = 1'b1;
        $display("fill base=%h aborted after %0d words", b, nrecv);
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    if (!aborted) begin
      check_value("fill_complete", 16'(done), 16'd1);
      if (gapmax == 0) check_value("fill_len", 16'(c - 1), 16'(7 + lat));
      $display("fill base=%h words=%0d cycles=%0d", b, nrecv, c);
    end
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst        = 1'b0;
    miss_detected     = 1'b0;
    miss_address      = 16'h0;
    memory_data_valid = 1'b0;
    memory_data       = 16'h0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      miss_detected     = 1'($urandom);
      miss_address      = 16'($urandom);
      memory_data_valid = 1'($urandom);
      memory_data       = 16'($urandom);
      @(negedge clk);
      check_all_zero("reset");
    end
    @(posedge clk); #1;
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;
    rst               = 1'b1;
    idle_cycle(1'b0);
    idle_cycle(1'b0);

    do_fill(16'h1236, 4, 0, 1'b0, -1);
    idle_cycle(1'b0);

    do_fill(16'h5A5A, 3, 3, 1'b1, -1);
    idle_cycle(1'b0);

    do_fill(16'h7770, 2, 0, 1'b0, 3);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    do_fill(16'h0000, 1, 0, 1'b0, -1);
    idle_cycle(1'b0);

    do_fill(16'hFFF0, 5, 1, 1'b0, -1);
    do_fill(16'h0010, 2, 0, 1'b0, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
